// File: rtl/adc_frame_packer_p.sv
// ADC-to-PCIe frame packer: packs channel samples MSB-first into 64-bit words,
// groups words into TLPs with a 40-bit header, and drives sync/polarisation outputs.
module adc_frame_packer_p #(
  parameter int SAMPLE_W      = 12,
  parameter int NUM_CH        = 2,
  parameter int WORDS_PER_TLP = 16
) (
  input  logic                       InputClock,
  input  logic                       rst,
  input  logic [NUM_CH*SAMPLE_W-1:0] adc_in,
  input  logic [15:0]                frame_len_words,
  input  logic [15:0]                pulse_offset,
  input  logic [15:0]                pulse_width,
  input  logic                       rr_mode,
  input  logic [3:0]                 ch_sel,
  input  logic [23:0]                frames_per_switch,
  input  logic                       auto_pol,
  input  logic                       manual_pol,
  input  logic                       test_mode,
  input  logic [15:0]                tlps_per_buffer,
  input  logic                       fifo_afull,
  output logic [63:0]                tlp_data,
  output logic                       data_we,
  output logic [39:0]                tlp_header,
  output logic                       header_we,
  output logic                       sync_pulse,
  output logic                       pol_out,
  output logic [15:0]                overflow_count
);

  localparam int SPW    = 64 / SAMPLE_W;
  localparam int PACK_W = SPW * SAMPLE_W;
  localparam int ACC_W  = PACK_W - SAMPLE_W;
  localparam int PAD_W  = 64 - PACK_W;
  localparam int PT_W   = $clog2(SPW);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WT_W   = $clog2(WORDS_PER_TLP);

  typedef enum logic {FILL, GAP} state_t;

  state_t              state_q, state_d;
  logic [PT_W-1:0]     pt_cnt;
  logic [PT_W-1:0]     gap_cnt;
  logic [15:0]         word_cnt;
  logic [WT_W-1:0]     words_in_tlp;
  logic [15:0]         tlp_cnt;
  logic [15:0]         buf_cnt;
  logic [23:0]         frame_cnt;
  logic                pol_state;
  logic [SAMPLE_W-1:0] test_cnt;
  logic [CH_W-1:0]     rr_ch;
  logic [3:0]          ch_id_tlp;
  logic                drop_active;
  logic                drop_pending;
  logic [ACC_W-1:0]    acc;
  logic [15:0]         cfg_len, cfg_off, cfg_wid;

  logic [3:0]          fixed_ch, sel_ch;
  logic [SAMPLE_W-1:0] ch_sample, sample;
  logic [PACK_W-1:0]   acc_next;
  logic [63:0]         word_next;
  logic                word_done, gap_done, tlp_first, tlp_last, drop_now, emit;
  logic                in_window;

  assign fixed_ch = ({1'b0, ch_sel} < 5'(NUM_CH)) ? ch_sel : 4'd0;
  assign sel_ch   = rr_mode ? 4'(rr_ch) : fixed_ch;

  always_comb begin
    ch_sample = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (sel_ch == 4'(k)) ch_sample = adc_in[k*SAMPLE_W +: SAMPLE_W];
  end

  assign sample    = test_mode ? test_cnt : ch_sample;
  assign acc_next  = {acc, sample};
  assign word_next = 64'(acc_next) << PAD_W;

  assign word_done = (state_q == FILL) && (pt_cnt == PT_W'(SPW - 1));
  assign gap_done  = (state_q == GAP) && (gap_cnt == PT_W'(SPW - 1));
  assign tlp_first = (words_in_tlp == '0);
  assign tlp_last  = (words_in_tlp == WT_W'(WORDS_PER_TLP - 1));
  // Backpressure is only looked at when a TLP's first word is due; the decision sticks for the TLP.
  assign drop_now  = tlp_first ? fifo_afull : drop_active;
  assign emit      = word_done && !drop_now;

  assign in_window = ({1'b0, word_cnt} >= {1'b0, cfg_off}) &&
                     ({1'b0, word_cnt} <= ({1'b0, cfg_off} + {1'b0, cfg_wid}));

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (word_done && (word_cnt == cfg_len)) state_d = GAP;
      GAP:     if (gap_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge InputClock) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge InputClock) begin
    if (rst) begin
      pt_cnt         <= '0;
      gap_cnt        <= '0;
      word_cnt       <= '0;
      words_in_tlp   <= '0;
      tlp_cnt        <= '0;
      buf_cnt        <= '0;
      frame_cnt      <= '0;
      pol_state      <= 1'b0;
      test_cnt       <= '0;
      rr_ch          <= '0;
      ch_id_tlp      <= '0;
      drop_active    <= 1'b0;
      drop_pending   <= 1'b0;
      acc            <= '0;
      tlp_data       <= '0;
      data_we        <= 1'b0;
      tlp_header     <= '0;
      header_we      <= 1'b0;
      sync_pulse     <= 1'b0;
      pol_out        <= 1'b0;
      overflow_count <= '0;
      cfg_len        <= frame_len_words;
      cfg_off        <= pulse_offset;
      cfg_wid        <= pulse_width;
    end else begin
      test_cnt   <= test_cnt + 1'b1;
      data_we    <= 1'b0;
      header_we  <= 1'b0;
      sync_pulse <= (state_q == FILL) && in_window;
      pol_out    <= auto_pol ? pol_state : manual_pol;

      if (state_q == FILL) begin
        acc <= acc_next[ACC_W-1:0];
        if (rr_mode)
          rr_ch <= (rr_ch == CH_W'(NUM_CH - 1)) ? '0 : rr_ch + 1'b1;
        if ((pt_cnt == '0) && tlp_first)
          ch_id_tlp <= rr_mode ? 4'hF : fixed_ch;

        if (word_done) begin
          pt_cnt       <= '0;
          word_cnt     <= word_cnt + 16'd1;
          words_in_tlp <= tlp_last ? '0 : words_in_tlp + 1'b1;

          if (tlp_first) begin
            drop_active <= fifo_afull;
            if (fifo_afull) begin
              drop_pending <= 1'b1;
              if (overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'd1;
            end
          end

          if (emit) begin
            tlp_data <= word_next;
            data_we  <= 1'b1;
          end

          // Header counters advance even for dropped TLPs so the host sees the gap.
          if (tlp_last) begin
            if (emit) begin
              header_we    <= 1'b1;
              tlp_header   <= {buf_cnt, tlp_cnt, ch_id_tlp, pol_state, drop_pending, 2'b11};
              drop_pending <= 1'b0;
            end
            if (tlp_cnt >= tlps_per_buffer) begin
              tlp_cnt <= '0;
              buf_cnt <= buf_cnt + 16'd1;
            end else begin
              tlp_cnt <= tlp_cnt + 16'd1;
            end
          end
        end else begin
          pt_cnt <= pt_cnt + 1'b1;
        end
      end else begin
        if (gap_done) begin
          gap_cnt  <= '0;
          word_cnt <= '0;
          cfg_len  <= frame_len_words;
          cfg_off  <= pulse_offset;
          cfg_wid  <= pulse_width;
          if (frame_cnt >= frames_per_switch) begin
            frame_cnt <= '0;
            pol_state <= ~pol_state;
          end else begin
            frame_cnt <= frame_cnt + 24'd1;
          end
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer_p.sv
// Directed bench for adc_frame_packer_p (SAMPLE_W=12 so SPW=5, NUM_CH=4, WORDS_PER_TLP=4).
module tb_adc_frame_packer_p;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] adc_in = '0;
  logic [15:0] frame_len_words = '0, pulse_offset = '0, pulse_width = '0;
  logic        rr_mode = 1'b0;
  logic [3:0]  ch_sel = '0;
  logic [23:0] frames_per_switch = '0;
  logic        auto_pol = 1'b0, manual_pol = 1'b0, test_mode = 1'b0;
  logic [15:0] tlps_per_buffer = '0;
  logic        fifo_afull = 1'b0;
  logic [63:0] tlp_data;
  logic        data_we;
  logic [39:0] tlp_header;
  logic        header_we;
  logic        sync_pulse;
  logic        pol_out;
  logic [15:0] overflow_count;

  int errors = 0;
  int checks = 0;

  adc_frame_packer_p #(.SAMPLE_W(12), .NUM_CH(4), .WORDS_PER_TLP(4)) dut (
    .InputClock(clock), .rst(rst), .adc_in(adc_in),
    .frame_len_words(frame_len_words), .pulse_offset(pulse_offset), .pulse_width(pulse_width),
    .rr_mode(rr_mode), .ch_sel(ch_sel), .frames_per_switch(frames_per_switch),
    .auto_pol(auto_pol), .manual_pol(manual_pol), .test_mode(test_mode),
    .tlps_per_buffer(tlps_per_buffer), .fifo_afull(fifo_afull),
    .tlp_data(tlp_data), .data_we(data_we), .tlp_header(tlp_header), .header_we(header_we),
    .sync_pulse(sync_pulse), .pol_out(pol_out), .overflow_count(overflow_count)
  );

  always #5 clock = ~clock;

  // Monitor: cycle index counts rising edges since reset release.
  int          cyc = 0;
  logic [63:0] words[$];
  int          word_cyc[$];
  logic [39:0] hdrs[$];
  int          sync_first = -1, sync_cnt = 0, pol_rise = -1, pol_fall = -1;

  always @(posedge clock) begin
    #1;
    if (rst) cyc = 0;
    else begin
      cyc++;
      if (data_we) begin
        words.push_back(tlp_data);
        word_cyc.push_back(cyc);
      end
      if (header_we) hdrs.push_back(tlp_header);
      if (sync_pulse) begin
        if (sync_first < 0) sync_first = cyc;
        if (cyc <= 25) sync_cnt++;
      end
      if (pol_out && pol_rise < 0) pol_rise = cyc;
      if (!pol_out && pol_rise >= 0 && pol_fall < 0) pol_fall = cyc;
    end
  end

  function automatic logic [63:0] wordAt(int i);
    return (i < words.size()) ? words[i] : 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  function automatic int wordCycAt(int i);
    return (i < word_cyc.size()) ? word_cyc[i] : -1;
  endfunction

  function automatic logic [63:0] hdrAt(int i);
    return (i < hdrs.size()) ? 64'(hdrs[i]) : 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic tm, input logic rr, input logic [3:0] chs, input logic [47:0] adc,
                               input logic [15:0] len, input logic [15:0] off, input logic [15:0] wid,
                               input logic [23:0] fps, input logic ap, input logic mp, input logic [15:0] tpb);
    @(negedge clock);
    rst = 1'b1;
    test_mode = tm; rr_mode = rr; ch_sel = chs; adc_in = adc;
    frame_len_words = len; pulse_offset = off; pulse_width = wid;
    frames_per_switch = fps; auto_pol = ap; manual_pol = mp; tlps_per_buffer = tpb;
    fifo_afull = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    words.delete(); word_cyc.delete(); hdrs.delete();
    sync_first = -1; sync_cnt = 0; pol_rise = -1; pol_fall = -1;
    rst = 1'b0;
  endtask

  task automatic waitCycle(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clock);
      #2;
      guard++;
    end
    if (cyc < n) checkOutput("wait_timeout", 64'(cyc), 64'(n));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Test-counter frames: frame = 4 words of 5 samples, then a 5-cycle gap.
    applyStimulus(1'b1, 1'b0, 4'd0, 48'd0, 16'd3, 16'd2, 16'd1, 24'd1, 1'b1, 1'b0, 16'd1);
    @(posedge clock); #2;
    checkOutput("reset_data_we", 64'(data_we), 64'd0);
    checkOutput("reset_tlp_data", tlp_data, 64'd0);
    waitCycle(102);
    checkOutput("tm_word0", wordAt(0), 64'h0000010020030040);
    checkOutput("tm_word1", wordAt(1), 64'h0050060070080090);
    checkOutput("tm_word4", wordAt(4), 64'h01901A01B01C01D0);
    checkOutput("tm_word0_cyc", 64'(wordCycAt(0)), 64'd5);
    checkOutput("tm_word_spacing", 64'(wordCycAt(1) - wordCycAt(0)), 64'd5);
    checkOutput("tm_gap_spacing", 64'(wordCycAt(4) - wordCycAt(3)), 64'd10);
    checkOutput("hdr0", hdrAt(0), 64'({16'd0, 16'd0, 4'd0, 1'b0, 1'b0, 2'b11}));
    checkOutput("hdr1", hdrAt(1), 64'({16'd0, 16'd1, 4'd0, 1'b0, 1'b0, 2'b11}));
    checkOutput("hdr2", hdrAt(2), 64'({16'd1, 16'd0, 4'd0, 1'b1, 1'b0, 2'b11}));
    checkOutput("hdr3", hdrAt(3), 64'({16'd1, 16'd1, 4'd0, 1'b1, 1'b0, 2'b11}));
    checkOutput("sync_first", 64'(sync_first), 64'd11);
    checkOutput("sync_len", 64'(sync_cnt), 64'd10);
    checkOutput("pol_rise", 64'(pol_rise), 64'd51);
    checkOutput("pol_fall", 64'(pol_fall), 64'd101);

    // Round-robin over channels holding constants 0..3.
    applyStimulus(1'b0, 1'b1, 4'd0, {12'd3, 12'd2, 12'd1, 12'd0}, 16'd3, 16'd0, 16'd0,
                  24'd100, 1'b0, 1'b0, 16'd100);
    waitCycle(22);
    checkOutput("rr_word0", wordAt(0), 64'h0000010020030000);
    checkOutput("rr_word1", wordAt(1), 64'h0010020030000010);
    checkOutput("rr_hdr0", hdrAt(0), 64'h00000000F3);

    // Out-of-range fixed channel falls back to channel 0; TLP 2 dropped under backpressure.
    applyStimulus(1'b0, 1'b0, 4'd7, {12'h333, 12'h222, 12'h111, 12'hABC}, 16'd3, 16'd0, 16'd3,
                  24'd1000, 1'b0, 1'b1, 16'd100);
    waitCycle(52);
    fifo_afull = 1'b1;
    waitCycle(67);
    fifo_afull = 1'b0;
    waitCycle(82);
    fifo_afull = 1'b1;
    waitCycle(88);
    fifo_afull = 1'b0;
    waitCycle(122);
    checkOutput("clamp_word0", wordAt(0), 64'hABCABCABCABCABC0);
    checkOutput("drop_word_count", 64'(words.size()), 64'd16);
    checkOutput("drop_hdr_count", 64'(hdrs.size()), 64'd4);
    checkOutput("drop_hdr2", hdrAt(2), 64'({16'd0, 16'd3, 4'd0, 1'b0, 1'b1, 2'b11}));
    checkOutput("drop_hdr3", hdrAt(3), 64'({16'd0, 16'd4, 4'd0, 1'b0, 1'b0, 2'b11}));
    checkOutput("overflow_count", 64'(overflow_count), 64'd1);
    checkOutput("manual_pol", 64'(pol_out), 64'd1);

    // Mid-frame reset clears every output after one edge.
    waitCycle(132);
    checkOutput("pre_rst_sync", 64'(sync_pulse), 64'd1);
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock); #1;
    checkOutput("rst_tlp_data", tlp_data, 64'd0);
    checkOutput("rst_data_we", 64'(data_we), 64'd0);
    checkOutput("rst_tlp_header", 64'(tlp_header), 64'd0);
    checkOutput("rst_header_we", 64'(header_we), 64'd0);
    checkOutput("rst_sync_pulse", 64'(sync_pulse), 64'd0);
    checkOutput("rst_pol_out", 64'(pol_out), 64'd0);
    checkOutput("rst_overflow", 64'(overflow_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
